// File: rtl/secuencia_lectura_rtc.sv
// secuencia_lectura_rtc
// Sequences one RTC read sweep over ten registers (seconds..timer). For each
// local index the matching RTC address is requested on the bus, and the
// returned byte is handed to the hold decoder with an active-low load strobe.
// Indices that belong to the group currently being edited by the user are
// skipped, so the value being typed in is not overwritten by the live RTC.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for iniciar; outputs parked, index/address held
// SKIP  | decide whether the current index is read or skipped
// REQ   | bus read requested, waiting for bus_done (bounded by TIMEOUT)
// LOAD  | one-cycle reg_rd low strobe at addr_mem_local = index
// NEXT  | advance index, or finish after index 9
// DONE  | one-cycle fin_lectura pulse, back to IDLE

module secuencia_lectura_rtc #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [1:0] funcion_conf_in,
    input  logic       bus_done,
    output logic       req_bus,
    output logic [7:0] dir_rtc,
    output logic [3:0] addr_mem_local,
    output logic       reg_rd,
    output logic [1:0] funcion_conf,
    output logic       busy,
    output logic       fin_lectura,
    output logic       error_to
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SKIP = 3'd1,
        ST_REQ  = 3'd2,
        ST_LOAD = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd9;

    state_t     state_q, state_d;
    logic [3:0] idx_q,   idx_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [1:0] conf_q,  conf_d;
    logic       err_q,   err_d;

    logic       skip_idx;
    logic       cnt_last;
    logic [7:0] dir_map;

    // The wait counter holds the number of REQ cycles already elapsed; the
    // current cycle is the last allowed one when that count + 1 hits TIMEOUT.
    assign cnt_last = (({1'b0, cnt_q} + 9'd1) == {1'b0, TIMEOUT});

    // Index belongs to the group the user is editing in the latched mode.
    always_comb begin
        skip_idx = 1'b0;
        case (conf_q)
            2'b01:   skip_idx = (idx_q <= 4'd2);
            2'b10:   skip_idx = (idx_q >= 4'd3) && (idx_q <= 4'd6);
            2'b11:   skip_idx = (idx_q >= 4'd7);
            default: skip_idx = 1'b0;
        endcase
    end

    // Local index to RTC register address: time/date block at 0x21, timer at 0x41.
    always_comb begin
        dir_map = 8'h00;
        case (idx_q)
            4'd0:    dir_map = 8'h21;
            4'd1:    dir_map = 8'h22;
            4'd2:    dir_map = 8'h23;
            4'd3:    dir_map = 8'h24;
            4'd4:    dir_map = 8'h25;
            4'd5:    dir_map = 8'h26;
            4'd6:    dir_map = 8'h27;
            4'd7:    dir_map = 8'h41;
            4'd8:    dir_map = 8'h42;
            4'd9:    dir_map = 8'h43;
            default: dir_map = 8'h00;
        endcase
    end

    // State, index, wait counter, latched mode and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 8'd0;
            conf_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            conf_q  <= conf_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; iniciar is only looked at in IDLE, so pulses during a
    // sweep are simply lost. bus_done wins over a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        conf_d  = conf_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (iniciar) begin
                    conf_d  = funcion_conf_in;
                    idx_d   = 4'd0;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = ST_SKIP;
                end
            end
            ST_SKIP: begin
                cnt_d   = 8'd0;
                state_d = skip_idx ? ST_NEXT : ST_REQ;
            end
            ST_REQ: begin
                if (bus_done) begin
                    cnt_d   = 8'd0;
                    state_d = ST_LOAD;
                end else if (cnt_last) begin
                    cnt_d   = 8'd0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            ST_LOAD: begin
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_SKIP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state so none of them depend
    // combinationally on the inputs, and reset forces them immediately.
    always_comb begin
        req_bus     = (state_q == ST_REQ);
        reg_rd      = (state_q != ST_LOAD);
        busy        = (state_q != ST_IDLE);
        fin_lectura = (state_q == ST_DONE);
        dir_rtc     = (state_q == ST_IDLE) ? 8'h00 : dir_map;
    end

    assign addr_mem_local = idx_q;
    assign funcion_conf   = conf_q;
    assign error_to       = err_q;

endmodule

// File: tb/tb_secuencia_lectura_rtc.sv
// Testbench for secuencia_lectura_rtc: randomized sweeps, a bus responder
// with random latency, and a scoreboard fed by a sweep-level reference model.

module tb_secuencia_lectura_rtc;

    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [1:0] funcion_conf_in;
    logic       bus_done = 1'b0;
    logic       req_bus;
    logic [7:0] dir_rtc;
    logic [3:0] addr_mem_local;
    logic       reg_rd;
    logic [1:0] funcion_conf;
    logic       busy;
    logic       fin_lectura;
    logic       error_to;

    secuencia_lectura_rtc #(.TIMEOUT(8'd200)) dut (
        .clk            (clk),
        .reset          (reset),
        .iniciar        (iniciar),
        .funcion_conf_in(funcion_conf_in),
        .bus_done       (bus_done),
        .req_bus        (req_bus),
        .dir_rtc        (dir_rtc),
        .addr_mem_local (addr_mem_local),
        .reg_rd         (reg_rd),
        .funcion_conf   (funcion_conf),
        .busy           (busy),
        .fin_lectura    (fin_lectura),
        .error_to       (error_to)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_STROBE = 0, EV_FIN = 1, EV_TO = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       addr;
        int       dir;
        int       mode;
        int       run;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  hang_idx = -1;
    int  exact_idx = -1;
    int  fixed_delay = -1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic fail_evt(input string name, input int act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: actual=%0d required=no event", name, act);
    endtask

    // Reference model: what a sweep should produce, from the register map rules.
    function automatic int dir_of(input int i);
        return (i < 7) ? (33 + i) : (65 + i - 7);
    endfunction

    function automatic bit skipped(input int m, input int i);
        case (m)
            1:       return (i >= 0 && i <= 2);
            2:       return (i >= 3 && i <= 6);
            3:       return (i >= 7 && i <= 9);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_sweep(input int m, input int hang, input int exact, input int stop_after);
        ev_t e;
        for (int i = 0; i < 10; i++) begin
            if (skipped(m, i)) continue;
            if (i == hang) begin
                e = '{kind: EV_TO, addr: i, dir: 0, mode: m, run: TO};
                exp_q.push_back(e);
                return;
            end
            e = '{kind: EV_STROBE, addr: i, dir: dir_of(i), mode: m, run: (i == exact) ? TO : 0};
            exp_q.push_back(e);
            if (i == stop_after) return;
        end
        e = '{kind: EV_FIN, addr: 9, dir: 0, mode: m, run: 0};
        exp_q.push_back(e);
    endtask

    // Bus responder: answers each request after a chosen number of cycles and
    // throws in stray bus_done pulses while no request is pending.
    int rcnt = 0;
    int target = 0;
    always @(negedge clk) begin
        if (reset) begin
            rcnt = 0;
            bus_done = 1'b0;
        end else if (req_bus) begin
            if (rcnt == 0) begin
                if (int'(addr_mem_local) == hang_idx) target = 100000;
                else if (int'(addr_mem_local) == exact_idx) target = TO - 1;
                else if (fixed_delay >= 0) target = fixed_delay;
                else target = $urandom_range(0, 5);
            end
            bus_done = (rcnt == target);
            rcnt++;
        end else begin
            rcnt = 0;
            bus_done = ($urandom_range(0, 5) == 0);
        end
    end

    // Monitor: pops the scoreboard on every strobe, completion and timeout.
    int   run = 0;
    logic prev_err = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            run = 0;
            prev_err = 1'b0;
        end else begin
            if (req_bus) run++;
            if (!reg_rd) begin
                if (exp_q.size() == 0) fail_evt("unexpected_strobe", int'(addr_mem_local));
                else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", int'(EV_STROBE), int'(e.kind));
                    chk("strobe_addr", int'(addr_mem_local), e.addr);
                    chk("strobe_dir", int'(dir_rtc), e.dir);
                    chk("strobe_mode", int'(funcion_conf), e.mode);
                    chk("strobe_req_low", int'(req_bus), 0);
                    if (e.run != 0) chk("strobe_req_cycles", run, e.run);
                    else chk("strobe_after_req", int'(run >= 1), 1);
                end
            end
            if (fin_lectura) begin
                if (exp_q.size() == 0) fail_evt("unexpected_fin", 1);
                else begin
                    e = exp_q.pop_front();
                    chk("fin_kind", int'(EV_FIN), int'(e.kind));
                    chk("fin_error_low", int'(error_to), 0);
                end
            end
            if (error_to && !prev_err) begin
                if (exp_q.size() == 0) fail_evt("unexpected_timeout", int'(addr_mem_local));
                else begin
                    e = exp_q.pop_front();
                    chk("timeout_kind", int'(EV_TO), int'(e.kind));
                    chk("timeout_addr", int'(addr_mem_local), e.addr);
                    chk("timeout_req_cycles", run, e.run);
                    chk("timeout_req_low", int'(req_bus), 0);
                    chk("timeout_busy_low", int'(busy), 0);
                end
            end
            prev_err = error_to;
            if (!req_bus) run = 0;
        end
    end

    task automatic pulse_start(input int m);
        funcion_conf_in = m[1:0];
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (busy && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk(name, int'(busy), 0);
    endtask

    task automatic do_sweep(input int m, input int hang, input int exact);
        hang_idx = hang;
        exact_idx = exact;
        model_sweep(m, hang, exact, -1);
        pulse_start(m);
        chk("busy_after_start", int'(busy), 1);
        chk("error_cleared_on_start", int'(error_to), 0);
        chk("mode_latched", int'(funcion_conf), m);
        wait_idle("sweep_ends");
        chk("idle_dir_zero", int'(dir_rtc), 0);
        chk("idle_addr_held", int'(addr_mem_local), (hang >= 0) ? hang : 9);
        chk("idle_error_flag", int'(error_to), (hang >= 0) ? 1 : 0);
        chk("idle_req_low", int'(req_bus), 0);
        chk("idle_reg_rd_high", int'(reg_rd), 1);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int idx;
        bit found;
        reset = 1'b1;
        iniciar = 1'b0;
        funcion_conf_in = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_req_bus", int'(req_bus), 0);
        chk("rst_reg_rd", int'(reg_rd), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dir", int'(dir_rtc), 0);
        chk("rst_addr", int'(addr_mem_local), 0);
        chk("rst_conf", int'(funcion_conf), 0);
        chk("rst_fin", int'(fin_lectura), 0);
        chk("rst_error", int'(error_to), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_without_start", int'(busy), 0);

        fixed_delay = 3;
        do_sweep(0, -1, -1);
        fixed_delay = -1;
        do_sweep(1, -1, -1);
        do_sweep(3, -1, -1);
        do_sweep(2, -1, -1);

        for (int k = 0; k < 12; k++) do_sweep($urandom_range(0, 3), -1, -1);

        // Timeout at index 4, then recovery by a fresh start.
        do_sweep($urandom_range(0, 1), 4, -1);
        do_sweep(0, -1, -1);

        // bus_done exactly on the last allowed cycle counts as success.
        do_sweep(0, -1, 4);

        // Timeout at a random non-skipped index.
        m = $urandom_range(0, 3);
        idx = $urandom_range(0, 9);
        while (skipped(m, idx)) idx = $urandom_range(0, 9);
        do_sweep(m, idx, -1);

        // Mode change and extra iniciar while busy are both ignored.
        hang_idx = -1;
        exact_idx = -1;
        model_sweep(0, -1, -1, -1);
        pulse_start(0);
        repeat (10) @(negedge clk);
        funcion_conf_in = 2'b10;
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        chk("mid_sweep_conf_held", int'(funcion_conf), 0);
        wait_idle("mid_sweep_done");
        repeat (20) @(negedge clk);
        chk("mid_sweep_single_run", int'(busy), 0);
        chk("mid_sweep_conf_final", int'(funcion_conf), 0);
        chk("mid_sweep_queue_empty", exp_q.size(), 0);

        // Reset during the LOAD of index 5.
        m = $urandom_range(0, 2);
        if (m == 2) m = 3;
        model_sweep(m, -1, -1, 5);
        pulse_start(m);
        found = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (!reg_rd && addr_mem_local == 4'd5) begin
                found = 1'b1;
                break;
            end
        end
        chk("reset_test_reached_load5", int'(found), 1);
        #1 reset = 1'b1;
        #1;
        chk("reset_mid_reg_rd", int'(reg_rd), 1);
        chk("reset_mid_busy", int'(busy), 0);
        chk("reset_mid_addr", int'(addr_mem_local), 0);
        chk("reset_mid_fin", int'(fin_lectura), 0);
        chk("reset_mid_req", int'(req_bus), 0);
        chk("reset_mid_dir", int'(dir_rtc), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset_waits_for_start", int'(busy), 0);
        chk("reset_queue_empty", exp_q.size(), 0);
        exp_q.delete();

        do_sweep($urandom_range(0, 3), -1, -1);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/secuencia_lectura_rtc.md
SECUENCIA_LECTURA_RTC -- requirements
Module: secuencia_lectura_rtc

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd200: max cycles to wait for bus_done per register before aborting.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port iniciar, input, 1 bit: one-cycle pulse requesting a full RTC read sweep.
REQ-005 SHALL have port funcion_conf_in, input, 2 bits: current mode (00 normal, 01 set time, 10 set date, 11 set timer).
REQ-006 SHALL have port bus_done, input, 1 bit: one-cycle pulse from the RTC bus-cycle generator; read data is valid on that cycle.
REQ-007 SHALL have port req_bus, output, 1 bit: level request for one RTC read cycle.
REQ-008 SHALL have port dir_rtc, output, 8 bits: RTC register address for the current read.
REQ-009 SHALL have port addr_mem_local, output, 4 bits: local register index 0..9, sent to the hold decoder.
REQ-010 SHALL have port reg_rd, output, 1 bit: active-low load strobe sent to the hold decoder.
REQ-011 SHALL have port funcion_conf, output, 2 bits: mode latched for the sweep, sent to the hold decoder.
REQ-012 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-013 SHALL have port fin_lectura, output, 1 bit: one-cycle pulse when a sweep completes normally.
REQ-014 SHALL have port error_to, output, 1 bit: sticky timeout flag; cleared by the next accepted iniciar.

Function
REQ-015 SHALL implement FSM states IDLE, SKIP, REQ, LOAD, NEXT, DONE.
REQ-016 In IDLE, SHALL accept iniciar as follows: latch funcion_conf_in into funcion_conf; set index to 0; clear error_to; go to SKIP. Else SHALL stay in IDLE.
REQ-017 In IDLE, SHALL ignore iniciar while busy; pulses that arrive mid-sweep are dropped, not queued.
REQ-018 In SKIP, SHALL skip the index when it belongs to the group under configuration: 0-2 for mode 01, 3-6 for mode 10, 7-9 for mode 11. Skipped indices go to NEXT with no bus request. All other indices go to REQ. Mode 00 skips nothing.
REQ-019 SHALL map index to dir_rtc as 0..9 -> 0x21,0x22,0x23,0x24,0x25,0x26,0x27,0x41,0x42,0x43. dir_rtc SHALL be 0x00 in IDLE.
REQ-020 In REQ, SHALL hold req_bus=1 and increment a wait counter each cycle. On bus_done, go to LOAD with req_bus=0 on the next cycle.
REQ-021 In REQ, if the counter reaches TIMEOUT without bus_done, SHALL set error_to=1, drop req_bus, and return to IDLE; fin_lectura SHALL NOT pulse.
REQ-022 In LOAD, SHALL drive reg_rd=0 for exactly one cycle with addr_mem_local equal to the current index. reg_rd SHALL be 1 in every other state.
REQ-023 In NEXT, if index=9 SHALL go to DONE; otherwise SHALL increment the index and go to SKIP.
REQ-024 In DONE, SHALL pulse fin_lectura for one cycle and return to IDLE.
REQ-025 addr_mem_local SHALL track the index continuously and hold its last value in IDLE; the index width is 4 bits, and values 10..15 are never produced.
REQ-026 funcion_conf SHALL stay constant for the whole sweep; changes on funcion_conf_in mid-sweep take effect only at the next iniciar.
REQ-027 A bus_done arriving outside REQ SHALL be ignored.
REQ-028 A bus_done arriving on the same cycle the counter reaches TIMEOUT SHALL be treated as success.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 Per non-skipped register, latency from entering REQ to the reg_rd strobe SHALL be (cycles until bus_done) + 1.

Reset
REQ-031 While reset=1, SHALL force, asynchronously: FSM=IDLE, index=0, addr_mem_local=0, wait counter=0, req_bus=0, reg_rd=1, funcion_conf=00, dir_rtc=0x00, busy=0, fin_lectura=0, error_to=0.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep immediately with no strobe or pulse; after release the block SHALL wait for a new iniciar.

Verification
REQ-033 Mode 00, iniciar, bus_done 3 cycles after each req_bus -> ten reg_rd low strobes at addr 0..9, dir_rtc 0x21..0x27 then 0x41..0x43, then one fin_lectura pulse.
REQ-034 Mode 01 -> no req_bus for indices 0-2, strobes only at 3..9. Mode 11 -> strobes only at 0..6.
REQ-035 Hold bus_done low at index 4 -> req_bus drops after 200 cycles, error_to=1, no fin_lectura, busy=0. The next iniciar clears error_to.
REQ-036 Change funcion_conf_in from 00 to 10 mid-sweep, and pulse iniciar during the sweep -> funcion_conf stays 00, one sweep only, skip set unchanged.
REQ-037 Assert reset during LOAD at index 5 -> reg_rd=1, busy=0, addr_mem_local=0 the same cycle, no fin_lectura.
REQ-038 bus_done on the exact TIMEOUT cycle -> strobe occurs, error_to stays 0.
